// File: rtl/rx232.sv
// rx232: 8N1 asynchronous serial receiver with oversampled bit timing,
// level-valid/acknowledge byte handshake and framing/overrun status.
module rx232 #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxck,
  input  logic       rxsd,
  input  logic       rxack,
  output logic [7:0] rxpd,
  output logic       rxrdy,
  output logic       ferr,
  output logic       ovr,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  localparam logic [3:0] HALF = 4'(OVS / 2 - 1);
  localparam logic [3:0] LAST = 4'(OVS - 1);

  state_t     state;
  logic       rc0;
  logic       rc1;
  logic       rs0;
  logic       rs;
  logic [3:0] tcnt;
  logic [2:0] bidx;
  logic [7:0] shf;
  logic       tick;
  logic       deliver;

  assign tick = rc0 & ~rc1;
  assign busy = (state != IDLE);

  // good stop bit on its evaluation tick
  assign deliver = tick && (state == STOP)
                && (tcnt == LAST) && rs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rc0   <= 1'b0;
      rc1   <= 1'b0;
      rs0   <= 1'b1;
      rs    <= 1'b1;
      state <= IDLE;
      tcnt  <= 4'd0;
      bidx  <= 3'd0;
      shf   <= 8'h00;
      rxpd  <= 8'h00;
      rxrdy <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      rc0 <= rxck;
      rc1 <= rc0;
      rs0 <= rxsd;
      rs  <= rs0;

      if (tick) begin
        unique case (state)
          IDLE: begin
            if (!rs) begin
              state <= START;
              tcnt  <= 4'd0;
            end
          end
          START: begin
            if (tcnt == HALF) begin
              tcnt <= 4'd0;
              bidx <= 3'd0;
              state <= rs ? IDLE : DATA;
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
          DATA: begin
            if (tcnt == LAST) begin
              shf  <= {rs, shf[7:1]};
              tcnt <= 4'd0;
              bidx <= bidx + 3'd1;
              if (bidx == 3'd7) state <= STOP;
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
          STOP: begin
            if (tcnt == LAST) begin
              tcnt  <= 4'd0;
              ferr  <= ~rs;
              state <= rs ? IDLE : BRK;
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
          BRK: begin
            if (rs) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end

      // an ack in the delivery clk frees the slot for the new byte
      if (deliver) begin
        if (!rxrdy || rxack) begin
          rxpd  <= shf;
          rxrdy <= 1'b1;
          if (rxack) ovr <= 1'b0;
        end else begin
          ovr <= 1'b1;
        end
      end else if (rxack) begin
        rxrdy <= 1'b0;
        ovr   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx232.sv
// tb_rx232: directed frame table plus hand sequences for false start,
// framing error/break, ack-at-delivery and reset mid-frame.
module tb_rx232;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxck = 1'b0;
  logic       rxsd = 1'b1;
  logic       rxack = 1'b0;
  logic [7:0] rxpd;
  logic       rxrdy;
  logic       ferr;
  logic       ovr;
  logic       busy;

  int tests = 0;
  int fails = 0;
  bit busy_bad;

  rx232 #(.OVS(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .rxck (rxck),
    .rxsd (rxsd),
    .rxack(rxack),
    .rxpd (rxpd),
    .rxrdy(rxrdy),
    .ferr (ferr),
    .ovr  (ovr),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always #40 rxck = ~rxck;

  // bench-side model of the rxck edge detector
  logic m0, m1, tm;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0 <= 1'b0;
      m1 <= 1'b0;
    end else begin
      m0 <= rxck;
      m1 <= m0;
    end
  end
  assign tm = m0 & ~m1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // returns at the negedge after the next tick edge
  task automatic next_tick(input bit ack);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tm && n < 64);
    if (!tm) begin
      tests++;
      fails++;
      $display("FAIL tick_timeout: got none expected tick");
    end
    if (ack) rxack = 1'b1;
    @(negedge clk);
    rxack = 1'b0;
  endtask

  // start bit drops just after tick T0; delivery tick is T0+153
  task automatic send_frame(input logic [7:0] d,
                            input bit stop,
                            input bit sim_ack,
                            input int abort_at);
    int b;
    busy_bad = 1'b0;
    next_tick(1'b0);
    for (int t = 0; t < 160; t++) begin
      b = t / 16;
      if (b == 0) rxsd = 1'b0;
      else if (b == 9) rxsd = stop;
      else rxsd = d[b-1];
      if (t == abort_at) begin
        rst = 1'b0;
        return;
      end
      next_tick(sim_ack && t == 152);
      if (t + 1 >= 1 && t + 1 <= 152 && !busy) busy_bad = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] d;
    bit         stop;
    bit         sim_ack;
    bit         ack_after;
    int         hold_low;
    logic [7:0] pd;
    bit         rdy;
    bit         fe;
    bit         ov;
  } vec_t;

  vec_t v[8];

  initial begin
    v[0] = '{8'hA5, 1, 0, 1, 0,  8'hA5, 1, 0, 0};
    v[1] = '{8'h3C, 1, 0, 1, 0,  8'h3C, 1, 0, 0};
    v[2] = '{8'h55, 0, 0, 0, 40, 8'h3C, 0, 1, 0};
    v[3] = '{8'h0F, 1, 0, 1, 0,  8'h0F, 1, 0, 0};
    v[4] = '{8'h11, 1, 0, 0, 0,  8'h11, 1, 0, 0};
    v[5] = '{8'h22, 1, 0, 0, 0,  8'h11, 1, 0, 1};
    v[6] = '{8'h33, 1, 1, 0, 0,  8'h33, 1, 0, 0};
    v[7] = '{8'h81, 1, 0, 0, 0,  8'h81, 1, 0, 0};

    repeat (30) @(negedge clk);
    chk("rst_rxpd", 32'(rxpd), 32'h00);
    chk("rst_rxrdy", 32'(rxrdy), 0);
    chk("rst_ferr", 32'(ferr), 0);
    chk("rst_ovr", 32'(ovr), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    repeat (4) next_tick(1'b0);

    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        next_tick(1'b0);
        rxsd = 1'b0;
        repeat (3) next_tick(1'b0);
        rxsd = 1'b1;
        repeat (12) next_tick(1'b0);
        chk("fs_busy", 32'(busy), 0);
        chk("fs_rxrdy", 32'(rxrdy), 0);
        chk("fs_rxpd", 32'(rxpd), 32'hA5);
        chk("fs_ferr", 32'(ferr), 0);
      end
      if (i == 7) begin
        send_frame(8'hFF, 1'b1, 1'b0, 85);
        #1;
        chk("mr_rxpd", 32'(rxpd), 32'h00);
        chk("mr_rxrdy", 32'(rxrdy), 0);
        chk("mr_ovr", 32'(ovr), 0);
        chk("mr_busy", 32'(busy), 0);
        repeat (40) @(negedge clk);
        chk("mr_hold_busy", 32'(busy), 0);
        chk("mr_hold_rxrdy", 32'(rxrdy), 0);
        rxsd = 1'b1;
        rst = 1'b1;
        repeat (20) next_tick(1'b0);
      end

      send_frame(v[i].d, v[i].stop, v[i].sim_ack, -1);
      chk($sformatf("v%0d_busy_frame", i), 32'(busy_bad), 0);
      if (v[i].hold_low > 0) begin
        repeat (v[i].hold_low) next_tick(1'b0);
        chk($sformatf("v%0d_brk_busy", i), 32'(busy), 1);
        rxsd = 1'b1;
        repeat (3) next_tick(1'b0);
      end
      chk($sformatf("v%0d_busy", i), 32'(busy), 0);
      chk($sformatf("v%0d_rxpd", i), 32'(rxpd), 32'(v[i].pd));
      chk($sformatf("v%0d_rxrdy", i), 32'(rxrdy), 32'(v[i].rdy));
      chk($sformatf("v%0d_ferr", i), 32'(ferr), 32'(v[i].fe));
      chk($sformatf("v%0d_ovr", i), 32'(ovr), 32'(v[i].ov));
      if (v[i].ack_after) begin
        @(negedge clk);
        rxack = 1'b1;
        @(negedge clk);
        rxack = 1'b0;
        chk($sformatf("v%0d_ack_rxrdy", i), 32'(rxrdy), 0);
        chk($sformatf("v%0d_ack_rxpd", i), 32'(rxpd), 32'(v[i].pd));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
